// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state type and constants for the convolution result reader
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_STREAM,
        ST_DONE
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int PTR_W          = $clog2(BYTES_PER_WORD);
    localparam int KERNEL_W       = 2;

endpackage

// File: rtl/conv_result_reader_if.sv
// rtl/conv_result_reader_if.sv - data-memory read port and result byte stream bundle
interface conv_result_reader_if #(
    parameter int ADDR_W = 8
);
    logic                         mem_re;
    logic [ADDR_W-1:0]            mem_addr;
    logic [31:0]                  mem_rdata;
    logic                         out_valid;
    logic                         out_ready;
    logic [7:0]                   out_data;
    logic [conv_pkg::KERNEL_W-1:0] out_kernel;
    logic                         out_last;

    modport master (
        output mem_re, mem_addr, out_valid, out_data, out_kernel, out_last,
        input  mem_rdata, out_ready
    );

    modport slave (
        input  mem_re, mem_addr, out_valid, out_data, out_kernel, out_last,
        output mem_rdata, out_ready
    );
endinterface

// File: rtl/conv_result_reader_word_unpacker.sv
// rtl/conv_result_reader_word_unpacker.sv - holds one fetched word and selects its bytes in order
module word_unpacker
    import conv_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        advance,
    input  logic [31:0] word_in,
    output logic [7:0]  byte_out,
    output logic        last_in_word
);

    logic [31:0]      hold;
    logic [PTR_W-1:0] ptr;

    always_ff @(posedge clock) begin
        if (!reset) begin
            hold <= '0;
            ptr  <= '0;
        end else if (load) begin
            hold <= word_in;
            ptr  <= '0;
        end else if (advance) begin
            ptr  <= ptr + 1'b1;
        end
    end

    assign byte_out     = hold[{ptr, 3'b000} +: 8];
    assign last_in_word = (ptr == PTR_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/conv_result_reader.sv
// rtl/conv_result_reader.sv - drains packed convolution results from memory as a byte stream
// Optional running byte checksum output enabled by CONV_READER_CHECKSUM_EN.
module conv_result_reader
    import conv_pkg::*;
#(
    parameter int NKERNEL = 2,
    parameter int ADDR_W  = 8,
    parameter int CNT_W   = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  npix,
    output logic              busy,
    output logic              done,
    conv_result_reader_if.master bus
`ifdef CONV_READER_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    localparam int TOT_W = CNT_W + 2;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   word_addr;
    logic [TOT_W-1:0]    total;
    logic [TOT_W-1:0]    byte_cnt;
    logic [KERNEL_W-1:0] kidx;
    logic                accept;
    logic                xfer;
    logic                last_byte;
    logic                load;
    logic                last_in_word;
    logic [7:0]          cur_byte;

    assign accept    = (state == ST_IDLE) && start;
    assign xfer      = (state == ST_STREAM) && bus.out_ready;
    assign last_byte = (byte_cnt == total - 1'b1);

    word_unpacker u_unpacker (
        .clock        (clock),
        .reset        (reset),
        .load         (load),
        .advance      (xfer),
        .word_in      (bus.mem_rdata),
        .byte_out     (cur_byte),
        .last_in_word (last_in_word)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Word address advances as soon as its read is issued, so the next FETCH is ready.
    always_ff @(posedge clock) begin
        if (!reset) begin
            word_addr <= '0;
            total     <= '0;
            byte_cnt  <= '0;
            kidx      <= '0;
        end else begin
            if (accept) begin
                word_addr <= base_addr;
                total     <= TOT_W'(npix) * TOT_W'(NKERNEL);
                byte_cnt  <= '0;
                kidx      <= '0;
            end
            if (state == ST_FETCH) begin
                word_addr <= word_addr + 1'b1;
            end
            if (xfer) begin
                byte_cnt <= byte_cnt + 1'b1;
                kidx     <= (kidx == KERNEL_W'(NKERNEL - 1)) ? '0 : kidx + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        busy           = (state != ST_IDLE);
        done           = 1'b0;
        load           = 1'b0;
        bus.mem_re     = 1'b0;
        bus.mem_addr   = '0;
        bus.out_valid  = 1'b0;
        bus.out_data   = '0;
        bus.out_kernel = '0;
        bus.out_last   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (npix != '0) ? ST_FETCH : ST_DONE;
                end
            end
            ST_FETCH: begin
                bus.mem_re   = 1'b1;
                bus.mem_addr = word_addr;
                state_nxt    = ST_WAIT;
            end
            ST_WAIT: begin
                load      = 1'b1;
                state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                bus.out_valid  = 1'b1;
                bus.out_data   = cur_byte;
                bus.out_kernel = kidx;
                bus.out_last   = last_byte;
                if (bus.out_ready) begin
                    if (last_byte) begin
                        state_nxt = ST_DONE;
                    end else if (last_in_word) begin
                        state_nxt = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef CONV_READER_CHECKSUM_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= '0;
        end else if (xfer) begin
            checksum <= checksum + {8'd0, cur_byte};
        end
    end
`endif

endmodule

// File: tb/tb_conv_result_reader.sv
// tb/tb_conv_result_reader.sv - randomized scoreboard bench for conv_result_reader
module tb_conv_result_reader;
    import conv_pkg::*;

    localparam int NK = 2;
    localparam int AW = 8;
    localparam int CW = 10;

    typedef struct {
        logic [7:0] data;
        logic [1:0] kern;
        logic       last;
    } exp_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] npix = '0;
    logic          busy;
    logic          done;
`ifdef CONV_READER_CHECKSUM_EN
    logic [15:0]   checksum;
`endif

    conv_result_reader_if #(.ADDR_W(AW)) bus ();

    conv_result_reader #(
        .NKERNEL (NK),
        .ADDR_W  (AW),
        .CNT_W   (CW)
    ) dut (
        .clock     (clk),
        .reset     (resetn),
        .start     (start),
        .base_addr (base_addr),
        .npix      (npix),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
`ifdef CONV_READER_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0]   mem [256];
    exp_t          exp_q [$];
    logic [AW-1:0] addr_q [$];
    int            n_checks = 0;
    int            n_fail = 0;
    bit            expect_done = 1'b0;
    bit            ready_rand = 1'b0;
    int            xfer_cnt = 0;
    int            sum_model = 0;
    bit            stall_prev = 1'b0;
    bit            last_prev = 1'b0;
    exp_t          held;
    exp_t          e_cur;

    always @(posedge clk) begin
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
    end

    always @(posedge clk) begin
        #1;
        bus.out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: samples at the falling edge, pops expectations on each handshake
    always @(negedge clk) begin
        if (!resetn) begin
            stall_prev = 1'b0;
            last_prev  = 1'b0;
        end else begin
            if (stall_prev) begin
                check("valid held during stall", 32'(bus.out_valid), 32'd1);
                check("data held during stall", 32'(bus.out_data), 32'(held.data));
                check("kernel held during stall", 32'(bus.out_kernel), 32'(held.kern));
                check("last held during stall", 32'(bus.out_last), 32'(held.last));
            end
            if (last_prev) check("done after last byte", 32'(done), 32'd1);
            if (bus.mem_re) begin
                if (addr_q.size() == 0) check("unexpected mem read", 32'd1, 32'd0);
                else check("mem read addr", 32'(bus.mem_addr), 32'(addr_q.pop_front()));
            end
            last_prev = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected byte", 32'd1, 32'd0);
                end else begin
                    e_cur = exp_q.pop_front();
                    check("out_data", 32'(bus.out_data), 32'(e_cur.data));
                    check("out_kernel", 32'(bus.out_kernel), 32'(e_cur.kern));
                    check("out_last", 32'(bus.out_last), 32'(e_cur.last));
                    sum_model = (sum_model + int'(e_cur.data)) % 65536;
                    last_prev = e_cur.last;
                end
                xfer_cnt++;
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            held = '{bus.out_data, bus.out_kernel, bus.out_last};
            if (done) begin
                check("done only when a drain is pending", 32'(expect_done), 32'd1);
                check("bytes left at done", 32'(exp_q.size()), 32'd0);
                check("reads left at done", 32'(addr_q.size()), 32'd0);
                expect_done = 1'b0;
            end
        end
    end

    task automatic load_expect(input logic [AW-1:0] b, input logic [CW-1:0] n);
        int          t;
        logic [31:0] w;
        t = int'(n) * NK;
        for (int i = 0; i < t; i++) begin
            w = mem[8'(int'(b) + i / 4)];
            exp_q.push_back('{w[8 * (i % 4) +: 8], 2'(i % NK), (i == t - 1)});
        end
        for (int k = 0; k < (t + 3) / 4; k++) addr_q.push_back(8'(int'(b) + k));
        sum_model = 0;
    endtask

    task automatic pulse_start(input logic [AW-1:0] b, input logic [CW-1:0] n);
        @(posedge clk); #1;
        base_addr   = b;
        npix        = n;
        start       = 1'b1;
        expect_done = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        base_addr = AW'($urandom);
        npix      = CW'($urandom);
        check("busy after start", 32'(busy), 32'd1);
`ifdef CONV_READER_CHECKSUM_EN
        check("checksum cleared by start", 32'(checksum), 32'd0);
`endif
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " mem_re"}, 32'(bus.mem_re), 32'd0);
        check({tag, " mem_addr"}, 32'(bus.mem_addr), 32'd0);
        check({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, " out_data"}, 32'(bus.out_data), 32'd0);
        check({tag, " out_kernel"}, 32'(bus.out_kernel), 32'd0);
        check({tag, " out_last"}, 32'(bus.out_last), 32'd0);
    endtask

    task automatic run_drain(input logic [AW-1:0] b, input logic [CW-1:0] n, input bit rnd);
        int c;
        ready_rand = rnd;
        load_expect(b, n);
        pulse_start(b, n);
        if (n == '0) begin
            check("zero-pixel done pulse", 32'(done), 32'd1);
        end else begin
            @(posedge clk); #1;
            check("no byte before latency", 32'(bus.out_valid), 32'd0);
            @(posedge clk); #1;
            check("first byte latency", 32'(bus.out_valid), 32'd1);
        end
        c = 0;
        while (expect_done && c < 2000) begin
            @(posedge clk);
            c++;
        end
        if (expect_done) check("done timeout", 32'd0, 32'd1);
        #1;
        check("busy low after done", 32'(busy), 32'd0);
`ifdef CONV_READER_CHECKSUM_EN
        check("checksum after drain", 32'(checksum), 32'(sum_model));
`endif
    endtask

    initial begin
        int x0;
        int c;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        resetn = 1'b1;

        mem[8'h10] = 32'h44332211;
        mem[8'h11] = 32'h88776655;
        run_drain(8'h10, 10'd4, 1'b0);
`ifdef CONV_READER_CHECKSUM_EN
        check("checksum basic drain", 32'(checksum), 32'h0264);
`endif
        run_drain(8'h20, 10'd3, 1'b0);
        run_drain(8'h30, 10'd1, 1'b1);
        run_drain(8'h40, 10'd10, 1'b1);
        run_drain(8'h50, 10'd0, 1'b0);
        run_drain(8'hFF, 10'd4, 1'b0);
        repeat (12) run_drain(AW'($urandom), CW'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));

        ready_rand = 1'b0;
        load_expect(8'h80, 10'd6);
        x0 = xfer_cnt;
        pulse_start(8'h80, 10'd6);
        c = 0;
        while (xfer_cnt < x0 + 3 && c < 200) begin
            @(posedge clk);
            c++;
        end
        if (xfer_cnt < x0 + 3) check("mid-drain byte timeout", 32'd0, 32'd1);
        #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("mid-drain reset");
        exp_q.delete();
        addr_q.delete();
        expect_done = 1'b0;
        resetn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("idle after abandoned drain", 32'(bus.out_valid), 32'd0);
        run_drain(8'h80, 10'd6, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_result_reader.md
Name: conv_result_reader

Overview:
- Drains convolution results from the data memory after a convolution pass finishes.
- The convolution engine writes NKERNEL result bytes per output pixel into data memory, packed 4 bytes per 32-bit word. This block reads those words back, unpacks them, and serialises them one byte at a time over a valid/ready stream to the host/output side.
- It is the reader end of the convolution's result-write path.

Parameters:
- NKERNEL, 2, number of kernels; result bytes stored per output pixel (1..4).
- ADDR_W, 8, data-memory word-address width.
- CNT_W, 10, width of the output-pixel count.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a drain; sampled only in IDLE.
- base_addr  in  ADDR_W  word address of the first result word; latched on an accepted start.
- npix  in  CNT_W  number of output pixels to drain; latched on an accepted start.
- busy  out  1  high from the cycle after an accepted start until the DONE cycle, inclusive.
- done  out  1  one-cycle completion pulse.
- mem_re  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory read word address.
- mem_rdata  in  32  read data; byte b sits at bits [8b+7:8b]; valid the cycle after mem_re.
- out_valid  out  1  stream byte valid.
- out_ready  in  1  downstream accept.
- out_data  out  8  result byte.
- out_kernel  out  2  kernel index of out_data.
- out_last  out  1  high with the final byte of the drain.

Behaviour:
- Reset (reset==0 at an edge):
  - FSM goes to IDLE; all counters and the holding register clear.
  - All outputs are 0 the following cycle.
  - Reset mid-drain abandons the drain immediately: no done pulse, and any pending byte is dropped.
- Totals on an accepted start:
  - T = npix*NKERNEL bytes (width CNT_W+2).
  - W = ceil(T/4) words, fetched from base_addr, base_addr+1, …, wrapping modulo 2^ADDR_W.
- FSM states: IDLE, FETCH, WAIT, STREAM, DONE.
  - IDLE: start==1 and npix!=0 -> FETCH. start==1 and npix==0 -> DONE (no memory reads). Otherwise stay.
  - FETCH: mem_re=1 and mem_addr=current word address for exactly one cycle -> WAIT.
  - WAIT: capture mem_rdata into the 32-bit holding register; byte pointer=0 -> STREAM.
  - STREAM: out_valid=1 presenting holding byte[ptr].
    - A byte transfers on a cycle with out_valid and out_ready both high.
    - On a transfer, ptr++ and the byte counter increments.
    - When the transfer emits byte T-1 -> DONE.
    - Else, if ptr was 3 -> FETCH with the next word address.
    - Else stay in STREAM.
  - DONE: done=1 for one cycle -> IDLE.
- Stream rules:
  - While out_valid is high, out_data, out_kernel and out_last hold stable until a transfer.
  - out_valid never drops without a transfer.
  - out_kernel = (global byte index) mod NKERNEL.
  - out_last = 1 only with byte T-1.
  - Unused bytes of a partially filled final word are discarded.
- Handshake and timing:
  - Throughput with out_ready held high: 4 bytes per 6 cycles (FETCH, WAIT, 4×STREAM).
  - Latency: first byte valid 3 cycles after the start edge.
- start while not in IDLE is ignored; base_addr and npix changes mid-drain have no effect.
- mem_re is 0 in every state except FETCH.

Optional Feature:
- Macro: CONV_READER_CHECKSUM_EN.
- When defined:
  - Extra output port checksum [15:0]: a 16-bit running sum, modulo 2^16, of every transferred out_data byte.
  - Cleared on reset and on an accepted start.
  - Holds its value after DONE.
- When undefined: the checksum port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package conv_pkg holds:
  - a state enum typedef for IDLE/FETCH/WAIT/STREAM/DONE;
  - constant BYTES_PER_WORD=4;
  - the kernel-index width constant.
- One natural sub-module: word_unpacker. It owns the 32-bit holding register, the byte pointer and the byte select, with load/advance inputs and a last-byte-of-word flag.
- The FSM and counters stay in the top level.

Test Plan:
- Basic drain: NKERNEL=2, base=0x10, npix=4, memory [0x10]=0x44332211, [0x11]=0x88776655, out_ready=1 -> bytes 11,22,33,44,55,66,77,88.
  - out_kernel sequence 0,1,0,1,…; out_last only on 0x88.
  - Exactly 2 mem_re pulses at 0x10 and 0x11; done one cycle after the last transfer.
- Partial word: NKERNEL=3, npix=1 -> 3 bytes emitted; byte 3 of the word discarded; out_last on byte 2; 1 read.
- Backpressure: out_ready toggled 1,0,0,1 pseudo-randomly -> no byte lost or duplicated; data stable while stalled; sequence unchanged.
- Zero and wrap:
  - npix=0 -> done pulse 1 cycle after start; no mem_re; no out_valid.
  - base=0xFF, npix=4, NKERNEL=2 -> reads at 0xFF then 0x00.
- Reset mid-drain: assert reset after 3 bytes -> next cycle all outputs 0, no done pulse. A subsequent start drains from scratch correctly.
- Checksum (macro defined): bytes 11..88 from the basic-drain scenario -> checksum=0x0264. A new start clears it to 0.
